// File: rtl/cacheline_pkg.sv
// Shared widths, state encoding and address helpers for the cache-line burst adaptor.
package cacheline_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef logic [CNT_W-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into 4-beat 64-bit memory bursts.
// Optional CACHELINE_ADAPTOR_WATCHDOG_EN adds a stall watchdog and the burst_err port.
module cacheline_adaptor
    import cacheline_pkg::*;
#(
    parameter int WDT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_addr,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    ,
    output logic              burst_err
`endif
);

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    adaptor_state_t    state_reg, state_next;
    beat_idx_t         cnt_reg, cnt_next;
    logic [31:0]       addr_reg, addr_next;
    logic [LINE_W-1:0] wdata_reg, wdata_next;
    logic [BEAT_W-1:0] rlane_reg [BEATS];
    logic [BEAT_W-1:0] wlane [BEATS];
    logic              in_burst;
    logic              rd_beat;
    logic              wdt_abort;

    assign in_burst = (state_reg == RD_BURST) || (state_reg == WR_BURST);
    assign rd_beat  = (state_reg == RD_BURST) && burst_resp;

    // Beat lane views: beat 0 occupies the lowest bits of the line.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
        assign wlane[gi] = wdata_reg[gi*BEAT_W +: BEAT_W];
        assign line_rdata[gi*BEAT_W +: BEAT_W] = rlane_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (line_write) begin
                    addr_next  = line_addr & LINE_MASK;
                    wdata_next = line_wdata;
                    state_next = WR_BURST;
                end else if (line_read) begin
                    addr_next  = line_addr & LINE_MASK;
                    state_next = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (burst_resp) begin
                    if (cnt_reg == LAST_BEAT) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + beat_idx_t'(1);
                    end
                end else if (wdt_abort) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            for (int i = 0; i < BEATS; i++) rlane_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            if (rd_beat) rlane_reg[cnt_reg] <= burst_rdata;
        end
    end

    assign line_resp   = (state_reg == DONE);
    assign burst_read  = (state_reg == RD_BURST);
    assign burst_write = (state_reg == WR_BURST);
    assign burst_addr  = addr_reg;
    assign burst_wdata = burst_write ? wlane[cnt_reg] : '0;

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_reg;
    logic             err_reg;

    // Abort after WDT_CYCLES consecutive burst cycles with no beat handshake.
    assign wdt_abort = in_burst && !burst_resp && (wdt_reg == WDT_W'(WDT_CYCLES - 1));
    assign burst_err = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (!in_burst || burst_resp || wdt_abort) wdt_reg <= '0;
            else                                      wdt_reg <= wdt_reg + WDT_W'(1);
            if (wdt_abort) err_reg <= 1'b1;
        end
    end
`else
    assign wdt_abort = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized self-checking bench for cacheline_adaptor against a line-level reference model.
module tb_cacheline_adaptor;
    import cacheline_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_read, line_write;
    logic [31:0]       line_addr;
    logic [LINE_W-1:0] line_wdata, line_rdata;
    logic              line_resp, burst_read, burst_write;
    logic [31:0]       burst_addr;
    logic [BEAT_W-1:0] burst_wdata, burst_rdata;
    logic              burst_resp;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    logic              burst_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [LINE_W-1:0] model_line;

    always #5 clk = ~clk;

    cacheline_adaptor #(.WDT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .line_read(line_read), .line_write(line_write),
        .line_addr(line_addr), .line_wdata(line_wdata),
        .line_rdata(line_rdata), .line_resp(line_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_addr(burst_addr), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
        , .burst_err(burst_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // One line transaction from an IDLE negedge to the following IDLE negedge.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                           input logic [255:0] rline, input int gap_min, input int gap_max,
                           input bit scramble, input bit keep_read, output int beat_cycles);
        logic [31:0] exp_addr;
        int beat, cyc, gap;
        exp_addr = {addr[31:5], 5'b0};
        beat = 0;
        cyc  = 0;
        line_write = wr;
        line_read  = !wr || keep_read;
        line_addr  = addr;
        line_wdata = wd;
        @(negedge clk);
        gap = $urandom_range(gap_max, gap_min);
        while (beat < 4 && cyc < 200) begin
            if (scramble) begin
                line_addr  = $urandom;
                line_wdata = rand_line();
            end
            check_eq("strobes", {burst_write, burst_read}, wr ? 2'b10 : 2'b01);
            check_eq("burst_addr", burst_addr, exp_addr);
            if (wr) check_eq("burst_wdata", burst_wdata, wd[64*beat +: 64]);
            if (gap == 0) begin
                burst_resp  = 1'b1;
                burst_rdata = rline[64*beat +: 64];
                beat++;
                gap = $urandom_range(gap_max, gap_min);
            end else begin
                burst_resp  = 1'b0;
                burst_rdata = {$urandom, $urandom};
                gap--;
            end
            @(negedge clk);
            cyc++;
        end
        burst_resp = 1'b0;
        if (beat < 4) check_eq("beat_timeout", beat, 4);
        beat_cycles = cyc;
        check_eq("line_resp_hi", line_resp, 1'b1);
        check_eq("strobes_done", {burst_write, burst_read}, 2'b00);
        if (!wr) model_line = rline;
        check_eq("line_rdata", line_rdata, model_line);
        $display("txn %s addr=%08h cycles=%0d", wr ? "WR" : "RD", addr, cyc);
        line_write = 1'b0;
        line_read  = keep_read;
        @(negedge clk);
        check_eq("line_resp_lo", line_resp, 1'b0);
    endtask

    initial begin
        int cyc;
        bit wr;
        rst = 1'b1;
        line_read = 0; line_write = 0; line_addr = '0; line_wdata = '0;
        burst_rdata = '0; burst_resp = 0;
        model_line = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_resp", line_resp, 1'b0);
        check_eq("rst_strobes", {burst_write, burst_read}, 2'b00);
        check_eq("rst_addr", burst_addr, 32'h0);
        check_eq("rst_wdata", burst_wdata, 64'h0);
        check_eq("rst_rdata", line_rdata, 256'h0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read with fixed beats A..D.
        run_txn(0, 32'h0000_1234, '0, {64'hD, 64'hC, 64'hB, 64'hA}, 0, 0, 0, 0, cyc);
        check_eq("rd_latency", cyc, 4);
        check_eq("rd_line_abcd", line_rdata, {64'hD, 64'hC, 64'hB, 64'hA});

        // Write with a response on every third cycle.
        run_txn(1, 32'h0000_8040, {64'd4, 64'd3, 64'd2, 64'd1}, '0, 2, 2, 0, 0, cyc);
        check_eq("wr_wait_cycles", cyc, 12);
        check_eq("wr_strobe_after", burst_write, 1'b0);

        // Simultaneous request: write first, then the still-pending read.
        run_txn(1, 32'h0000_2000, rand_line(), '0, 0, 1, 0, 1, cyc);
        run_txn(0, 32'h0000_2000, '0, rand_line(), 0, 1, 0, 0, cyc);

        // Address/data changes during a write burst must not leak through.
        run_txn(1, 32'hCAFE_0060, rand_line(), '0, 0, 2, 1, 0, cyc);

        // Reset after two beats of a read.
        line_read = 1'b1;
        line_addr = 32'h0000_4000;
        @(negedge clk);
        repeat (2) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        burst_resp = 1'b0;
        rst = 1'b1;
        line_read = 1'b0;
        @(negedge clk);
        check_eq("midrst_strobe", burst_read, 1'b0);
        check_eq("midrst_rdata", line_rdata, 256'h0);
        check_eq("midrst_resp", line_resp, 1'b0);
        model_line = '0;
        rst = 1'b0;
        @(negedge clk);
        run_txn(0, 32'h0000_4000, '0, rand_line(), 0, 1, 0, 0, cyc);

        // Randomized mix of reads and writes.
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom_range(1, 0));
            run_txn(wr, $urandom, rand_line(), rand_line(), 0, 3,
                    1'($urandom_range(1, 0)), 0, cyc);
        end

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
        // No burst_resp ever arrives: the watchdog must complete the transaction.
        line_read = 1'b1;
        line_addr = 32'h0000_0100;
        @(negedge clk);
        cyc = 0;
        while (!line_resp && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("wdt_cycles", cyc, 16);
        check_eq("wdt_err", burst_err, 1'b1);
        line_read = 1'b0;
        @(negedge clk);
        check_eq("wdt_idle", {line_resp, burst_read}, 2'b00);
        check_eq("wdt_sticky", burst_err, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("wdt_rst_clear", burst_err, 1'b0);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side responder for the 256-bit line interface driven by the L2 cache and write-buffer path (pmem_read/pmem_write/pmem_addr/pmem_wdata/pmem_resp).
- Serves each line request as a fixed-length burst of 64-bit beats on the physical-memory port.
- Returns an assembled line on reads. Returns a single-cycle completion pulse on both reads and writes.

Parameters:
- LINE_W, 256, line width in bits.
- BEAT_W, 64, burst beat width in bits; BEATS = LINE_W/BEAT_W = 4.
- WDT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- line_read  in  1  line read request, held until line_resp
- line_write  in  1  line write request, held until line_resp
- line_addr  in  32  line address; bits [4:0] ignored
- line_wdata  in  256  write line
- line_rdata  out  256  assembled read line
- line_resp  out  1  one-cycle completion pulse
- burst_read  out  1  memory read burst, held for the whole burst
- burst_write  out  1  memory write burst, held for the whole burst
- burst_addr  out  32  line-aligned burst address
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  current read beat
- burst_resp  in  1  beat accepted/valid, one pulse per beat
- burst_err  out  1  sticky watchdog error (present only with the optional feature)

Behaviour:
- Reset and clocking
  - One clock domain, clk. rst is synchronous and active-high.
  - Reset values: state IDLE, beat counter 0, line_rdata 0, line_resp 0, burst_read 0, burst_write 0, burst_addr 0, burst_wdata 0, burst_err 0.
- State machine: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE
  - line_write=1: latch {line_addr[31:5],5'b0} into addr_q and line_wdata into wdata_q; go to WR_BURST.
  - Else if line_read=1: latch addr_q; go to RD_BURST.
  - Both requests asserted: write wins. The read stays pending and is served as the next transaction.
- RD_BURST
  - burst_read=1, burst_addr=addr_q.
  - On each burst_resp, write burst_rdata into line_rdata[BEAT_W*cnt +: BEAT_W], beat 0 at the lowest bits, then increment cnt.
  - burst_resp with cnt==BEATS-1: clear cnt to 0 and go to DONE.
  - No burst_resp: hold state and outputs.
- WR_BURST
  - burst_write=1, burst_addr=addr_q, burst_wdata=wdata_q[BEAT_W*cnt +: BEAT_W] (combinational from cnt).
  - cnt advances on burst_resp. The final beat goes to DONE.
- DONE
  - line_resp=1 for exactly one cycle; burst_read and burst_write are 0; go to IDLE.
  - The requester must drop its request in the cycle after line_resp. A request seen in IDLE is always a new transaction.
- Latency: with back-to-back burst_resp, request seen at cycle 0, beats at cycles 1–4, line_resp at cycle 5 (BEATS+2 cycles total).
- line_rdata holds its value until the next read burst overwrites it. It is valid at line_resp and afterwards.
- Address and data inputs are sampled only in IDLE. Input changes during a burst have no effect.
- Reset mid-burst: the next cycle is IDLE, burst strobes drop, and the partial line is discarded. line_rdata is zeroed by reset.
- Counter wraps modulo BEATS; only the state transition ends a burst.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in RD_BURST/WR_BURST and clears on every burst_resp.
  - When it reaches WDT_CYCLES, burst_err is set (sticky until rst), the burst is aborted, and the block goes to DONE, so line_resp still fires.
  - line_rdata contents are undefined for the beats that did not arrive.
- Undefined: no counter and no burst_err port; a missing burst_resp stalls the block indefinitely.

Decomposition:
- Package cacheline_pkg holds:
  - LINE_W, BEAT_W, BEATS;
  - the state enum typedef adaptor_state_t;
  - a beat-index typedef of width $clog2(BEATS);
  - the line-offset mask constant 32'hFFFF_FFE0.
- No sub-module needed. The optional watchdog counter may be a small sub-module, burst_watchdog, instantiated only under the macro.

Test Plan:
- Read, zero wait: line_read, line_addr=32'h0000_1234, beats 64'hA, B, C, D on consecutive cycles.
  -> burst_addr=32'h0000_1220; line_resp at cycle 5; line_rdata={D,C,B,A}.
- Write with waits: line_write, line_wdata = four beats 1..4, burst_resp every 3rd cycle.
  -> burst_wdata sequence 1,2,3,4, each held until its resp; one line_resp; burst_write low afterwards.
- Simultaneous request: line_read=line_write=1.
  -> write burst first with line_resp; then the read burst and a second line_resp.
- Reset after beat 2 of a read.
  -> next cycle burst_read=0 and line_rdata=0; a new read completes normally afterwards.
- Input change mid-burst: line_addr/line_wdata changed during WR_BURST.
  -> burst_addr and beats unchanged.
- Watchdog (macro defined, WDT_CYCLES=16): no burst_resp.
  -> burst_err=1 and line_resp pulse after 16 cycles; block back in IDLE.
